alarm_ctrl: RTL and testbench
=============================

// Module: alarm_ctrl
// PURPOSE
//  Alarm controller downstream of the seconds/minutes (modulo-60) and hours (modulo-24) counters.
//  - Compares the running time with the programmed alarm time.
//  - Drives ring, snooze and stop behaviour with a 4-state FSM.
//  - Produces a gated buzzer output for the top level.
// PARAMETERS
//  RING_SEC    60   ticks of ringing before auto-stop (return to ARMED)
//  SNOOZE_SEC  300  ticks spent in SNOOZE before re-ringing
//  MAX_SNOOZE  3    snoozes allowed per alarm event (used only with ALARM_SNOOZE_LIMIT_EN)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-low reset
//  tick_1hz    in   1  one-cycle 1 Hz enable, same pulse that advances the time counters
//  cur_sec     in   6  current seconds, 0-59
//  cur_min     in   6  current minutes, 0-59
//  cur_hr      in   5  current hours, 0-23
//  alm_min     in   6  alarm minutes, 0-59
//  alm_hr      in   5  alarm hours, 0-23
//  alarm_en    in   1  alarm arm switch (level)
//  snooze_btn  in   1  debounced single-cycle pulse
//  stop_btn    in   1  debounced single-cycle pulse
//  state       out  2  00 DISABLED, 01 ARMED, 10 RINGING, 11 SNOOZE
//  ringing     out  1  high in RINGING
//  buzzer      out  1  beep pattern, toggles on each tick_1hz while RINGING, else 0
//  snooze_used out  4  snoozes taken for the current alarm event
// BEHAVIOUR
//  Reset (rst=0, async)
//   - state=DISABLED; ringing=0, buzzer=0, snooze_used=0; all internal counters=0.
//  Match detection
//   - hit = (cur_hr==alm_hr) & (cur_min==alm_min) & (cur_sec==0).
//   - hit is registered every cycle. match_evt is its rising edge (1 cycle, 1-cycle latency).
//   - Result: at most one event per matching minute, whatever tick phase.
//  FSM transitions (all registered; priority top to bottom)
//   - alarm_en=0, any state -> DISABLED next cycle; clears counters, buzzer, snooze_used.
//   - DISABLED:
//       alarm_en=1 -> ARMED.
//   - ARMED:
//       match_evt -> RINGING; ring_cnt=0, buzzer=1, snooze_used=0.
//   - RINGING:
//       stop_btn -> ARMED; buzzer=0.
//       snooze_btn (when permitted) -> SNOOZE; snz_cnt=0, snooze_used+1, buzzer=0.
//       tick_1hz with ring_cnt==RING_SEC-1 -> ARMED (auto-stop).
//       other tick_1hz -> ring_cnt+1, buzzer toggles.
//   - SNOOZE:
//       stop_btn -> ARMED.
//       tick_1hz with snz_cnt==SNOOZE_SEC-1 -> RINGING; ring_cnt=0, buzzer=1.
//       other tick_1hz -> snz_cnt+1.
//  Simultaneous events and boundaries
//   - stop_btn beats snooze_btn beats the tick timeout in the same cycle.
//   - Buttons are ignored in DISABLED and ARMED.
//   - match_evt is ignored outside ARMED: no retrigger while RINGING or SNOOZE.
//   - After a stop in the same minute the registered hit stays high, so there is no second edge and no re-ring.
//   - Changing alm_* while ARMED takes effect on the next compare cycle.
//   - A match created by that change fires immediately if cur_sec==0.
//   - Counters are sized with $clog2 of their limit and never exceed limit-1.
//   - snooze_used saturates at 15.
// CONFIGURATION
//  ALARM_SNOOZE_LIMIT_EN
//   - Defined: snooze_btn in RINGING is honoured only while snooze_used < MAX_SNOOZE.
//     Otherwise it is ignored: keeps ringing until stop_btn or auto-stop.
//   - Undefined: unlimited snoozes; MAX_SNOOZE unused; snooze_used still counts (saturating).
// TESTING
//  1. rst=0 mid-RINGING -> state=00, buzzer=0, ringing=0, snooze_used=0 asynchronously.
//  2. alarm_en=1, alm=07:30; counters step 07:29:59->07:30:00 -> state=10 one cycle after hit, buzzer=1.
//  3. RINGING, no buttons, 60 ticks -> state=01 on the 60th tick; buzzer toggled 59 times, then 0.
//  4. RINGING, snooze_btn -> state=11, snooze_used=1; 300 ticks -> state=10.
//     stop_btn -> 01, with no re-ring that minute.
//  5. stop_btn and snooze_btn in the same cycle in RINGING -> state=01, snooze_used unchanged.
//  6. With ALARM_SNOOZE_LIMIT_EN, MAX_SNOOZE=3: 4th snooze_btn -> stays 10, snooze_used=3.
//     Without the macro: 4th snooze_btn -> 11, snooze_used=4.
//     alarm_en=0 in SNOOZE -> 00 next cycle.

Source files
------------

// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the clock core and the alarm controller.
// The master side drives the time, the alarm setting, the tick and the user controls.
// The slave side (alarm_ctrl) returns the FSM state and the buzzer drive.
interface alarm_ctrl_if;
    logic       tick_1hz;
    logic [5:0] cur_sec;
    logic [5:0] cur_min;
    logic [4:0] cur_hr;
    logic [5:0] alm_min;
    logic [4:0] alm_hr;
    logic       alarm_en;
    logic       snooze_btn;
    logic       stop_btn;
    logic [1:0] state;
    logic       ringing;
    logic       buzzer;
    logic [3:0] snooze_used;

    modport master (
        output tick_1hz, cur_sec, cur_min, cur_hr, alm_min, alm_hr,
               alarm_en, snooze_btn, stop_btn,
        input  state, ringing, buzzer, snooze_used
    );

    modport slave (
        input  tick_1hz, cur_sec, cur_min, cur_hr, alm_min, alm_hr,
               alarm_en, snooze_btn, stop_btn,
        output state, ringing, buzzer, snooze_used
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm controller: compares running time with the alarm setting and runs the
// DISABLED / ARMED / RINGING / SNOOZE state machine that drives the buzzer.
// Optional feature macro: ALARM_SNOOZE_LIMIT_EN caps snoozes per alarm event
// at MAX_SNOOZE. Without it, snoozes are unlimited and snooze_used only counts.
module alarm_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input logic        clk,
    input logic        rst,
    alarm_ctrl_if.slave bus
);

    localparam int RING_W = $clog2(RING_SEC);
    localparam int SNZ_W  = $clog2(SNOOZE_SEC);

    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SEC - 1);
    localparam logic [3:0]        USED_MAX  = 4'hF;

    typedef enum logic [1:0] {
        S_DISABLED = 2'b00,
        S_ARMED    = 2'b01,
        S_RINGING  = 2'b10,
        S_SNOOZE   = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic               hit;
    logic               hit_q, hit_d;
    logic               match_evt;
    logic [RING_W-1:0]  ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0]   snz_cnt_q, snz_cnt_d;
    logic               buzzer_q, buzzer_d;
    logic [3:0]         snooze_used_q, snooze_used_d;
    logic               snooze_ok;
    logic               ring_done;
    logic               snz_done;
    logic               snooze_req;

    // Time compare: the alarm fires only on second 0 of the programmed minute.
    assign hit = (bus.cur_hr == bus.alm_hr) &&
                 (bus.cur_min == bus.alm_min) &&
                 (bus.cur_sec == 6'd0);

    // A match event is the first cycle of hit; holding hit_q high for the rest
    // of the matching second prevents a re-ring after an early stop.
    assign hit_d     = hit;
    assign match_evt = hit & ~hit_q;

    assign ring_done = (ring_cnt_q == RING_LAST);
    assign snz_done  = (snz_cnt_q == SNZ_LAST);

`ifdef ALARM_SNOOZE_LIMIT_EN
    // Snooze is honoured only while this alarm event still has snoozes left.
    assign snooze_ok = (32'(snooze_used_q) < MAX_SNOOZE);
`else
    // Unlimited snoozes; the limit parameter has no effect in this build.
    logic [31:0] unused_max_snooze;
    assign unused_max_snooze = 32'(MAX_SNOOZE);
    assign snooze_ok         = 1'b1;
`endif

    assign snooze_req = bus.snooze_btn & snooze_ok;

    // State register and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_DISABLED;
            hit_q         <= 1'b0;
            ring_cnt_q    <= '0;
            snz_cnt_q     <= '0;
            buzzer_q      <= 1'b0;
            snooze_used_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q       <= state_d;
            hit_q         <= hit_d;
            ring_cnt_q    <= ring_cnt_d;
            snz_cnt_q     <= snz_cnt_d;
            buzzer_q      <= buzzer_d;
            snooze_used_q <= snooze_used_d;
        end
    end

    // Next-state logic: disarm wins, then stop, then snooze, then tick timeout.
    always_comb begin
        // NOTE: default first so no path through this block leaves state_d unassigned (no latch).
        state_d = state_q;
        if (!bus.alarm_en) begin
            state_d = S_DISABLED;
        end else begin
            case (state_q)
                S_DISABLED: state_d = S_ARMED;
                S_ARMED: begin
                    if (match_evt) state_d = S_RINGING;
                end
                S_RINGING: begin
                    if (bus.stop_btn)                  state_d = S_ARMED;
                    else if (snooze_req)               state_d = S_SNOOZE;
                    else if (bus.tick_1hz && ring_done) state_d = S_ARMED;
                end
                S_SNOOZE: begin
                    if (bus.stop_btn)                 state_d = S_ARMED;
                    else if (bus.tick_1hz && snz_done) state_d = S_RINGING;
                end
                default: state_d = S_DISABLED;
            endcase
        end
    end

    // Counter, buzzer and snooze bookkeeping, following the same priority.
    always_comb begin
        ring_cnt_d    = ring_cnt_q;
        snz_cnt_d     = snz_cnt_q;
        buzzer_d      = buzzer_q;
        snooze_used_d = snooze_used_q;
        if (!bus.alarm_en) begin
            ring_cnt_d    = '0;
            snz_cnt_d     = '0;
            buzzer_d      = 1'b0;
            snooze_used_d = '0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (match_evt) begin
                        ring_cnt_d    = '0;
                        buzzer_d      = 1'b1;
                        snooze_used_d = '0;
                    end
                end
                S_RINGING: begin
                    if (bus.stop_btn) begin
                        buzzer_d = 1'b0;
                    end else if (snooze_req) begin
                        snz_cnt_d = '0;
                        buzzer_d  = 1'b0;
                        if (snooze_used_q != USED_MAX) snooze_used_d = snooze_used_q + 4'd1;
                    end else if (bus.tick_1hz) begin
                        if (ring_done) begin
                            ring_cnt_d = '0;
                            buzzer_d   = 1'b0;
                        end else begin
                            ring_cnt_d = ring_cnt_q + 1'b1;
                            buzzer_d   = ~buzzer_q;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (bus.stop_btn) begin
                        buzzer_d = 1'b0;
                    end else if (bus.tick_1hz) begin
                        if (snz_done) begin
                            snz_cnt_d  = '0;
                            ring_cnt_d = '0;
                            buzzer_d   = 1'b1;
                        end else begin
                            snz_cnt_d = snz_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs straight from registers so the top level sees glitch-free drive.
    always_comb begin
        bus.state       = state_q;
        bus.ringing     = (state_q == S_RINGING);
        bus.buzzer      = buzzer_q;
        bus.snooze_used = snooze_used_q;
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios plus a random soak,
// all compared against a behavioural model of the alarm rules.
module tb_alarm_ctrl;

    localparam int RING_SEC   = 60;
    localparam int SNOOZE_SEC = 300;
    localparam int MAX_SNOOZE = 3;
    localparam int DAY        = 86400;

    localparam int M_OFF   = 0;
    localparam int M_ARMED = 1;
    localparam int M_RING  = 2;
    localparam int M_SNZ   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    alarm_ctrl_if bus();

    alarm_ctrl #(
        .RING_SEC  (RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC),
        .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode plus seconds spent ringing / snoozing and snoozes taken.
    int m_mode;
    int m_ring;
    int m_snz;
    int m_used;
    bit m_hit_prev;
    int now;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_time(input int t);
        now = t;
        bus.cur_hr  = 5'(now / 3600);
        bus.cur_min = 6'((now / 60) % 60);
        bus.cur_sec = 6'(now % 60);
    endtask

    function automatic int alarm_sec();
        return int'(bus.alm_hr) * 3600 + int'(bus.alm_min) * 60;
    endfunction

    task automatic model_reset();
        m_mode = M_OFF; m_ring = 0; m_snz = 0; m_used = 0; m_hit_prev = 1'b0;
    endtask

    function automatic bit snooze_allowed();
`ifdef ALARM_SNOOZE_LIMIT_EN
        return m_used < MAX_SNOOZE;
`else
        return 1'b1;
`endif
    endfunction

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        bit hit_now;
        bit evt;
        hit_now = (bus.cur_hr == bus.alm_hr) && (bus.cur_min == bus.alm_min) && (bus.cur_sec == 6'd0);
        evt = hit_now && !m_hit_prev;
        m_hit_prev = hit_now;
        if (!bus.alarm_en) begin
            m_mode = M_OFF; m_ring = 0; m_snz = 0; m_used = 0;
        end else begin
            case (m_mode)
                M_OFF: m_mode = M_ARMED;
                M_ARMED: if (evt) begin m_mode = M_RING; m_ring = 0; m_used = 0; end
                M_RING: begin
                    if (bus.stop_btn) m_mode = M_ARMED;
                    else if (bus.snooze_btn && snooze_allowed()) begin
                        m_mode = M_SNZ; m_snz = 0;
                        m_used = (m_used < 15) ? m_used + 1 : 15;
                    end else if (bus.tick_1hz) begin
                        if (m_ring == RING_SEC - 1) m_mode = M_ARMED;
                        else m_ring++;
                    end
                end
                default: begin
                    if (bus.stop_btn) m_mode = M_ARMED;
                    else if (bus.tick_1hz) begin
                        if (m_snz == SNOOZE_SEC - 1) begin m_mode = M_RING; m_ring = 0; end
                        else m_snz++;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},   32'(bus.state),       m_mode);
        check({tag, ".ringing"}, 32'(bus.ringing),     32'(m_mode == M_RING));
        check({tag, ".buzzer"},  32'(bus.buzzer),      32'(m_mode == M_RING && (m_ring % 2) == 0));
        check({tag, ".used"},    32'(bus.snooze_used), m_used);
    endtask

    // One clock with the current inputs; pulses last exactly this cycle.
    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        if (bus.tick_1hz) set_time((now + 1) % DAY);
        bus.tick_1hz   = 1'b0;
        bus.snooze_btn = 1'b0;
        bus.stop_btn   = 1'b0;
        check_all(tag);
    endtask

    task automatic tick_step(input string tag);
        bus.tick_1hz = 1'b1;
        step(tag);
    endtask

    // Bring the controller to RINGING via a genuine :59 -> :00 rollover.
    task automatic go_alarm();
        bus.alarm_en = 1'b1;
        bus.stop_btn = 1'b1;
        step("ga_stop");
        step("ga_idle");
        set_time((alarm_sec() + DAY - 1) % DAY);
        step("ga_pre");
        tick_step("ga_tick");
        step("ga_ring");
        check("ga_ringing", 32'(bus.ringing), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int toggles;
        logic prev_buz;
        int t;

        bus.tick_1hz = 1'b0; bus.snooze_btn = 1'b0; bus.stop_btn = 1'b0;
        bus.alarm_en = 1'b0; bus.alm_hr = 5'd12; bus.alm_min = 6'd0;
        set_time(0);
        model_reset();

        // Reset state.
        #12;
        check_all("reset");
        @(posedge clk); #1; rst = 1'b1;
        step("disabled");
        bus.alarm_en = 1'b1;
        step("arm");
        check("arm_state", 32'(bus.state), 1);

        // Match on 07:29:59 -> 07:30:00.
        bus.alm_hr = 5'd7; bus.alm_min = 6'd30;
        set_time(7 * 3600 + 29 * 60 + 59);
        step("t2_pre");
        tick_step("t2_rollover");
        check("t2_not_yet", 32'(bus.state), 1);
        step("t2_ring");
        check("t2_state", 32'(bus.state), 2);
        check("t2_buzzer", 32'(bus.buzzer), 1);

        // Ring out 60 ticks, counting buzzer edges.
        toggles = 0;
        prev_buz = bus.buzzer;
        for (int i = 1; i <= RING_SEC; i++) begin
            tick_step("t3_ring");
            if (bus.buzzer !== prev_buz) toggles++;
            prev_buz = bus.buzzer;
            if (i == RING_SEC - 1) check("t3_still_ring", 32'(bus.state), 2);
        end
        check("t3_toggles", toggles, RING_SEC - 1);
        check("t3_state", 32'(bus.state), 1);
        check("t3_buzzer", 32'(bus.buzzer), 0);

        // Random alarm time; stop inside the matching second must not re-ring.
        bus.alm_hr = 5'($urandom_range(0, 23));
        bus.alm_min = 6'($urandom_range(0, 59));
        go_alarm();
        bus.stop_btn = 1'b1;
        step("norering_stop");
        for (int i = 0; i < 5; i++) step("norering_hold");
        check("norering_state", 32'(bus.state), 1);
        tick_step("norering_tick");

        // Snooze, full snooze period, then stop+snooze together.
        go_alarm();
        bus.snooze_btn = 1'b1;
        step("t4_snooze");
        check("t4_state", 32'(bus.state), 3);
        check("t4_used", 32'(bus.snooze_used), 1);
        for (int i = 1; i <= SNOOZE_SEC; i++) begin
            tick_step("t4_wait");
            if (i == SNOOZE_SEC - 1) check("t4_still_snz", 32'(bus.state), 3);
        end
        check("t4_rering", 32'(bus.state), 2);
        check("t4_rering_buz", 32'(bus.buzzer), 1);
        bus.stop_btn = 1'b1; bus.snooze_btn = 1'b1;
        step("t5_both");
        check("t5_state", 32'(bus.state), 1);
        check("t5_used", 32'(bus.snooze_used), 1);

        // Disarm while snoozing.
        go_alarm();
        bus.snooze_btn = 1'b1;
        step("dis_snz");
        tick_step("dis_tick");
        bus.alarm_en = 1'b0;
        step("dis_off");
        check("dis_state", 32'(bus.state), 0);
        check("dis_used", 32'(bus.snooze_used), 0);
        bus.alarm_en = 1'b1;
        step("dis_rearm");

        // Snooze limit: four presses in one alarm event.
        go_alarm();
        for (int k = 1; k <= 3; k++) begin
            bus.snooze_btn = 1'b1;
            step("t6_snz");
            for (int i = 0; i < SNOOZE_SEC; i++) tick_step("t6_wait");
        end
        bus.snooze_btn = 1'b1;
        step("t6_fourth");
`ifdef ALARM_SNOOZE_LIMIT_EN
        check("t6_state", 32'(bus.state), 2);
        check("t6_used", 32'(bus.snooze_used), 3);
`else
        check("t6_state", 32'(bus.state), 3);
        check("t6_used", 32'(bus.snooze_used), 4);
`endif
        bus.stop_btn = 1'b1;
        step("t6_stop");

        // Moving the alarm onto the current :00 second fires at once.
        t = $urandom_range(0, 1439) * 60;
        set_time(t);
        bus.alm_hr = 5'((t / 3600 + 1) % 24);
        bus.alm_min = bus.cur_min;
        step("move_pre");
        step("move_armed");
        check("move_armed_st", 32'(bus.state), 1);
        bus.alm_hr = bus.cur_hr;
        step("move_fire");
        check("move_fire_st", 32'(bus.state), 2);

        // Random soak around the alarm minute.
        for (int i = 0; i < 800; i++) begin
            bus.tick_1hz   = ($urandom_range(0, 1) == 0);
            bus.snooze_btn = ($urandom_range(0, 15) == 0);
            bus.stop_btn   = ($urandom_range(0, 31) == 0);
            bus.alarm_en   = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 59) == 0)
                set_time((alarm_sec() + DAY - int'($urandom_range(0, 3))) % DAY);
            if ($urandom_range(0, 149) == 0) begin
                bus.alm_hr  = bus.cur_hr;
                bus.alm_min = bus.cur_min;
            end
            step("soak");
        end

        // Asynchronous reset in the middle of ringing.
        go_alarm();
        tick_step("rst_tick");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_state", 32'(bus.state), 0);
        check("rst_ringing", 32'(bus.ringing), 0);
        check("rst_buzzer", 32'(bus.buzzer), 0);
        check("rst_used", 32'(bus.snooze_used), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
